// File: rtl/fetch_unit_pkg.sv
// Shared constants for the fetch stage: default widths, reset PC and the
// canonical NOP encoding, plus a small saturating-increment helper used by
// the optional performance counters.
package fetch_unit_pkg;

  localparam int          XLEN_DEFAULT     = 32;
  localparam int          ILEN             = 32;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;  // addi x0, x0, 0
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Increment a 32-bit event counter, sticking at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc32(input logic [31:0] value, input logic en);
    if (en && (value != 32'hFFFF_FFFF)) begin
      sat_inc32 = value + 32'd1;
    end else begin
      sat_inc32 = value;
    end
  endfunction

endpackage

// File: rtl/fetch_unit_sync_fifo.sv
// Small synchronous FIFO built from flops. Flush empties it in one cycle and
// takes priority over push/pop. The head entry is presented combinationally
// from the storage flops, so it is stable for as long as it is not popped.
module sync_fifo #(
  parameter int W = 8,
  parameter int D = 4
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [W-1:0]           data_in,
  output logic [W-1:0]           data_out,
  output logic [$clog2(D+1)-1:0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int AW = (D > 1) ? $clog2(D) : 1;
  localparam int CW = $clog2(D + 1);

  logic [W-1:0]  mem_q [D];
  logic [W-1:0]  mem_d [D];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push_s, do_pop_s;

  // Advance a pointer, wrapping explicitly so non-power-of-two depths work.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    if (p == AW'(D - 1)) begin
      ptr_inc = '0;
    end else begin
      ptr_inc = p + AW'(1);
    end
  endfunction

  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(D));
  assign count     = count_q;
  assign data_out  = mem_q[rd_ptr_q];
  // A push into a full FIFO is only honoured when the head leaves in the same cycle.
  assign do_push_s = push & (~full | pop);
  assign do_pop_s  = pop & ~empty;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push_s) begin
        mem_d[wr_ptr_q] = data_in;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      count_d = count_q + CW'(do_push_s) - CW'(do_pop_s);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: issues word fetches with several requests in
// flight, buffers returned words with their PCs, and flushes on redirect.
// Responses that belong to abandoned requests (redirect or reset) are
// counted in 'discard' and dropped as they return.
// Optional macro FETCH_PERF_CNT_EN adds stall/bubble/flush event counters.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int              XLEN            = XLEN_DEFAULT,
  parameter int              FIFO_DEPTH      = 4,
  parameter int              MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_PC        = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            i_clk,
  input  logic            i_reset,
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_gnt,
  input  logic            i_imem_rvalid,
  input  logic [ILEN-1:0] i_imem_rdata,
  output logic            o_if_valid,
  output logic [ILEN-1:0] o_if_instr,
  output logic [XLEN-1:0] o_if_pc,
  input  logic            i_if_ready,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     o_perf_stall_cycles,
  output logic [31:0]     o_perf_bubble_cycles,
  output logic [31:0]     o_perf_flush_count
`endif
);

  localparam int OW  = $clog2(MAX_OUTSTANDING + 1);
  localparam int FCW = $clog2(FIFO_DEPTH + 1);
  localparam int PW  = ILEN + XLEN;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [OW-1:0]   outstanding_q, outstanding_d;
  logic [OW-1:0]   discard_q, discard_d;
  logic [OW-1:0]   outstanding_next_s;

  logic            req_s, grant_s, rvalid_cnt_s, resp_keep_s, inflight_ok_s;
  logic            pf_pop_s, pf_empty_s, pf_full_s;
  logic [FCW-1:0]  pf_count_s;
  logic [PW-1:0]   pf_head_s;
  logic            pcq_empty_s, pcq_full_s;
  logic [OW-1:0]   pcq_count_s;
  logic [XLEN-1:0] pcq_head_s;

  // Every live in-flight request owns a queued PC; the rest are being discarded.
  assign inflight_ok_s = (int'(pcq_count_s) + int'(discard_q)) == int'(outstanding_q);

  // Credit: never let buffered + in-flight words exceed the prefetch FIFO.
  assign req_s = ~i_reset
               & (int'(outstanding_q) < MAX_OUTSTANDING)
               & ((int'(pf_count_s) + int'(outstanding_q)) < FIFO_DEPTH)
               & ~pf_full_s & ~pcq_full_s & inflight_ok_s;

  assign grant_s            = req_s & i_imem_gnt;
  assign rvalid_cnt_s       = i_imem_rvalid & (outstanding_q != '0);
  assign outstanding_next_s = outstanding_q + OW'(grant_s) - OW'(rvalid_cnt_s);
  assign resp_keep_s        = i_imem_rvalid & (discard_q == '0) & ~i_redirect & ~pcq_empty_s;
  assign pf_pop_s           = ~pf_empty_s & i_if_ready & ~i_redirect;

  assign o_imem_req  = req_s;
  assign o_imem_addr = fetch_pc_q;
  assign o_if_valid  = ~pf_empty_s;
  assign o_if_instr  = pf_empty_s ? NOP_INSTR : pf_head_s[PW-1:XLEN];
  assign o_if_pc     = pf_empty_s ? '0 : pf_head_s[XLEN-1:0];

  // Fetch PC, in-flight count and discard count; reset and redirect both
  // turn everything still in flight into responses to be discarded.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    outstanding_d = outstanding_next_s;
    discard_d     = discard_q;
    if (i_reset) begin
      fetch_pc_d = RESET_PC;
      discard_d  = outstanding_next_s;
    end else if (i_redirect) begin
      fetch_pc_d = {i_redirect_pc[XLEN-1:2], 2'b00};
      discard_d  = outstanding_next_s;
    end else begin
      if (grant_s) begin
        fetch_pc_d = fetch_pc_q + XLEN'(4);
      end else begin
        fetch_pc_d = fetch_pc_q;
      end
      if (i_imem_rvalid && (discard_q != '0)) begin
        discard_d = discard_q - OW'(1);
      end else begin
        discard_d = discard_q;
      end
    end
  end

  // Fetch-control registers (reset is folded into the next-state logic).
  always_ff @(posedge i_clk) begin
    fetch_pc_q    <= fetch_pc_d;
    outstanding_q <= outstanding_d;
    discard_q     <= discard_d;
  end

  // PCs of granted requests, consumed in order as their responses return.
  sync_fifo #(.W(XLEN), .D(MAX_OUTSTANDING)) u_pc_queue (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .push     (grant_s & ~i_redirect),
    .pop      (resp_keep_s),
    .flush    (i_redirect),
    .data_in  (fetch_pc_q),
    .data_out (pcq_head_s),
    .count    (pcq_count_s),
    .empty    (pcq_empty_s),
    .full     (pcq_full_s)
  );

  // Prefetch buffer of {instruction, pc} toward decode.
  sync_fifo #(.W(PW), .D(FIFO_DEPTH)) u_prefetch (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .push     (resp_keep_s),
    .pop      (pf_pop_s),
    .flush    (i_redirect),
    .data_in  ({i_imem_rdata, pcq_head_s}),
    .data_out (pf_head_s),
    .count    (pf_count_s),
    .empty    (pf_empty_s),
    .full     (pf_full_s)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_q, stall_d, bubble_q, bubble_d, flush_q, flush_d;

  // Saturating event counters for decode stalls, empty-buffer bubbles and flushes.
  always_comb begin
    stall_d  = stall_q;
    bubble_d = bubble_q;
    flush_d  = flush_q;
    if (i_reset) begin
      stall_d  = 32'd0;
      bubble_d = 32'd0;
      flush_d  = 32'd0;
    end else begin
      stall_d  = sat_inc32(stall_q, ~pf_empty_s & ~i_if_ready);
      bubble_d = sat_inc32(bubble_q, pf_empty_s);
      flush_d  = sat_inc32(flush_q, i_redirect);
    end
  end

  // Counter registers.
  always_ff @(posedge i_clk) begin
    stall_q  <= stall_d;
    bubble_q <= bubble_d;
    flush_q  <= flush_d;
  end

  assign o_perf_stall_cycles  = stall_q;
  assign o_perf_bubble_cycles = bubble_q;
  assign o_perf_flush_count   = flush_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: randomized memory/decode/redirect stimulus with a
// scoreboard. The reference model says decode must see the consecutive word
// addresses starting at the last redirect target (or reset PC), each with the
// memory word stored at that address.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam int          XLEN = 32;
  localparam int          FD   = 4;
  localparam int          MO   = 2;
  localparam logic [31:0] RPC  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_gnt = 1'b0;
  logic        i_imem_rvalid = 1'b0;
  logic [31:0] i_imem_rdata = 32'd0;
  logic        o_if_valid;
  logic [31:0] o_if_instr;
  logic [31:0] o_if_pc;
  logic        i_if_ready = 1'b1;
  logic        i_redirect = 1'b0;
  logic [31:0] i_redirect_pc = 32'd0;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] o_perf_stall_cycles, o_perf_bubble_cycles, o_perf_flush_count;
  logic [31:0] m_stall = 32'd0, m_bubble = 32'd0, m_flush = 32'd0;
`endif

  always #5 clk = ~clk;

  fetch_unit #(.XLEN(XLEN), .FIFO_DEPTH(FD), .MAX_OUTSTANDING(MO), .RESET_PC(RPC)) dut (
    .i_clk         (clk),
    .i_reset       (i_reset),
    .o_imem_req    (o_imem_req),
    .o_imem_addr   (o_imem_addr),
    .i_imem_gnt    (i_imem_gnt),
    .i_imem_rvalid (i_imem_rvalid),
    .i_imem_rdata  (i_imem_rdata),
    .o_if_valid    (o_if_valid),
    .o_if_instr    (o_if_instr),
    .o_if_pc       (o_if_pc),
    .i_if_ready    (i_if_ready),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc)
`ifdef FETCH_PERF_CNT_EN
    ,
    .o_perf_stall_cycles  (o_perf_stall_cycles),
    .o_perf_bubble_cycles (o_perf_bubble_cycles),
    .o_perf_flush_count   (o_perf_flush_count)
`endif
  );

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;

  mreq_t       mem_q[$];
  exp_t        exp_q[$];
  logic [31:0] exp_next = RPC;

  int checks = 0, failures = 0, pops = 0, cyc = 0;
  int gnt_mode = 0, rdy_mode = 0, lat_min = 1, lat_max = 1, redir_pct = 0;
  bit force_redir = 1'b0, mon_en = 1'b0;
  logic [31:0] force_tgt = 32'd0;

  // Monitor-side state
  logic [31:0] issue_pc = RPC, prev_addr = 32'd0, prev_pc = 32'd0, prev_instr = 32'd0;
  bit          prev_wait = 1'b0, prev_stall = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Driver: memory, decode and redirect stimulus; refills the expected queue.
  always @(posedge clk) begin
    #2;
    cyc++;
    case (gnt_mode)
      0:       i_imem_gnt = 1'b1;
      1:       i_imem_gnt = 1'b0;
      default: i_imem_gnt = ($urandom_range(0, 99) < 60);
    endcase
    case (rdy_mode)
      0:       i_if_ready = 1'b1;
      1:       i_if_ready = 1'b0;
      default: i_if_ready = ($urandom_range(0, 99) < 70);
    endcase
    if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
      i_imem_rvalid = 1'b1;
      i_imem_rdata  = mem_word(mem_q[0].addr);
      void'(mem_q.pop_front());
    end else begin
      i_imem_rvalid = 1'b0;
      i_imem_rdata  = $urandom;
    end
    i_redirect = 1'b0;
    if ($urandom_range(0, 3) == 0) i_redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
    else                           i_redirect_pc = $urandom;
    if (!i_reset && (force_redir || (redir_pct > 0 && $urandom_range(1, 100) <= redir_pct))) begin
      i_redirect = 1'b1;
      if (force_redir) i_redirect_pc = force_tgt;
      force_redir = 1'b0;
    end
    if (i_reset) begin
      exp_q.delete();
      exp_next = RPC;
    end else if (i_redirect) begin
      exp_q.delete();
      exp_next = i_redirect_pc & ~32'd3;
    end
    while (exp_q.size() < 8) begin
      exp_q.push_back(exp_t'{exp_next, mem_word(exp_next)});
      exp_next = exp_next + 32'd4;
    end
    if (o_imem_req && i_imem_gnt)
      mem_q.push_back(mreq_t'{o_imem_addr, cyc + int'($urandom_range(lat_min, lat_max))});
  end

  // Monitor: scoreboard pops on each accepted handshake, plus protocol checks.
  always @(negedge clk) begin
    if (mon_en) begin
      if (i_reset) begin
        issue_pc   = RPC;
        prev_wait  = 1'b0;
        prev_stall = 1'b0;
`ifdef FETCH_PERF_CNT_EN
        m_stall = 32'd0; m_bubble = 32'd0; m_flush = 32'd0;
`endif
      end else begin
`ifdef FETCH_PERF_CNT_EN
        check("perf_stall", o_perf_stall_cycles, m_stall);
        check("perf_bubble", o_perf_bubble_cycles, m_bubble);
        check("perf_flush", o_perf_flush_count, m_flush);
        if (o_if_valid && !i_if_ready) m_stall++;
        if (!o_if_valid) m_bubble++;
        if (i_redirect) m_flush++;
`endif
        if (prev_wait) begin
          check("req_held", o_imem_req, 1);
          check("addr_held", o_imem_addr, prev_addr);
        end
        if (prev_stall) begin
          check("stall_valid", o_if_valid, 1);
          check("stall_pc", o_if_pc, prev_pc);
          check("stall_instr", o_if_instr, prev_instr);
        end
        if (i_redirect) begin
          issue_pc = i_redirect_pc & ~32'd3;
        end else if (o_imem_req && i_imem_gnt) begin
          check("issue_addr", o_imem_addr, issue_pc);
          issue_pc = issue_pc + 32'd4;
        end
        check("inflight_bound", (mem_q.size() <= MO), 1);
        if (o_if_valid && i_if_ready && !i_redirect) begin
          if (exp_q.size() == 0) begin
            check("exp_queue_nonempty", 0, 1);
          end else begin
            check("if_pc", o_if_pc, exp_q[0].pc);
            check("if_instr", o_if_instr, exp_q[0].instr);
            void'(exp_q.pop_front());
          end
          pops++;
        end
        prev_wait  = o_imem_req && !i_imem_gnt && !i_redirect;
        prev_addr  = o_imem_addr;
        prev_stall = o_if_valid && !i_if_ready && !i_redirect;
        prev_pc    = o_if_pc;
        prev_instr = o_if_instr;
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    i_reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    i_reset = 1'b0;
  endtask

  initial begin
    int n;
    int p0;
    bit seen;
    logic [31:0] held;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    mon_en = 1'b1;
    @(negedge clk);
    check("rst_req", o_imem_req, 0);
    check("rst_valid", o_if_valid, 0);
    check("rst_instr", o_if_instr, NOP_INSTR);
    check("rst_pc", o_if_pc, 0);

    // Back-to-back fetch, latency 1: first valid in the third cycle after release
    @(posedge clk); #1;
    i_reset = 1'b0;
    n = 0; seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      n++;
      if (o_if_valid) begin seen = 1'b1; break; end
    end
    check("first_valid_seen", seen, 1);
    check("first_valid_cycle", n, 3);
    check("first_pc", o_if_pc, RPC);
    repeat (20) @(posedge clk);

    // Decode stalled: FIFO fills to depth, requests stop, then drains in order
    #1; rdy_mode = 1;
    do_reset();
    repeat (15) @(posedge clk);
    @(negedge clk);
    check("full_req_low", o_imem_req, 0);
    check("full_none_inflight", mem_q.size(), 0);
    check("full_valid", o_if_valid, 1);
    @(posedge clk); #1;
    gnt_mode = 1; rdy_mode = 0;
    p0 = pops;
    repeat (10) @(posedge clk);
    check("drain_count", pops - p0, FD);

    // Grant withheld: address held, advances by one word on the grant
    @(negedge clk);
    held = o_imem_addr;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("nogrant_req", o_imem_req, 1);
    check("nogrant_addr", o_imem_addr, held);
    @(posedge clk); #1; gnt_mode = 0;
    @(posedge clk);
    @(negedge clk);
    check("grant_advance", o_imem_addr, held + 32'd4);

    // Latency 3, redirect with two requests in flight
    @(posedge clk); #1;
    gnt_mode = 0; lat_min = 3; lat_max = 3;
    seen = 1'b0;
    repeat (30) begin
      @(posedge clk); #1;
      if (mem_q.size() == MO) begin
        force_tgt = 32'h0000_0103; force_redir = 1'b1; seen = 1'b1;
        break;
      end
    end
    check("two_inflight_seen", seen, 1);
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (o_if_valid && !i_redirect) begin seen = 1'b1; break; end
    end
    check("redirect_valid_seen", seen, 1);
    check("redirect_first_pc", o_if_pc, 32'h0000_0100);

    // Randomized traffic with redirects and one mid-run reset
    @(posedge clk); #1;
    gnt_mode = 2; rdy_mode = 2; lat_min = 1; lat_max = 4; redir_pct = 5;
    p0 = pops;
    repeat (1500) @(posedge clk);
    do_reset();
    repeat (1500) @(posedge clk);
    check("random_progress", (pops - p0 >= 200), 1);

    #1; redir_pct = 0;
    repeat (5) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
